// File: rtl/pipe_run_ctrl_pkg.sv
// Shared definitions for the pipeline run-control sequencer:
// run-state encodings and default timing constants.
package pipe_run_ctrl_pkg;

  typedef enum logic [2:0] {
    RS_HALT = 3'd0,
    RS_RUN  = 3'd1,
    RS_STEP = 3'd2,
    RS_TRAP = 3'd3
  } run_state_e;

  localparam int DEF_DB_CNT      = 16;
  localparam int DEF_DB_W        = 5;
  localparam int DEF_STEP_CYCLES = 1;
  localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pipe_run_ctrl_btn_debounce.sv
// Step-button conditioning: 2-flop synchronizer, stability-counter debounce,
// and a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
  import pipe_run_ctrl_pkg::*;
#(
  parameter int DB_CNT = DEF_DB_CNT,
  parameter int DB_W   = DEF_DB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_evt
);

  logic            sync_1;
  logic            sync_2;
  logic [DB_W-1:0] db_cnt;
  logic            level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      db_cnt  <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_q <= level;
      // Any cycle that agrees with the current level restarts the stability window.
      if (sync_2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CNT - 1)) begin
        level  <= sync_2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Both terms are flop outputs, so the pulse is exactly one clean cycle wide.
  assign rise_evt = level & ~level_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run-control sequencer: chooses free run, halt, single-step burst or trap stop
// each cycle and drives the pipeline stall request plus an advance-cycle counter.
module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int DB_CNT      = DEF_DB_CNT,
  parameter int DB_W        = DEF_DB_W,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             trap,
  output logic             stall_req,
  output logic             step_done,
  output logic             trapped,
  output logic [2:0]       run_state,
  output logic [CNT_W-1:0] adv_cnt
);

  run_state_e state;
  logic [7:0] step_ctr;
  logic       run_meta;
  logic       run_sync;
  logic       step_level;
  logic       step_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_meta <= run_sw;
      run_sync <= run_meta;
    end
  end

  btn_debounce #(
    .DB_CNT(DB_CNT),
    .DB_W  (DB_W)
  ) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (step_btn),
    .level   (step_level),
    .rise_evt(step_evt)
  );

  // Trap outranks everything; a step event arriving outside HALT is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RS_HALT;
      step_ctr  <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (trap) begin
        state <= RS_TRAP;
      end else begin
        case (state)
          RS_TRAP: state <= RS_TRAP;
          RS_HALT: begin
            if (halt_req) begin
              state <= RS_HALT;
            end else if (run_sync) begin
              state <= RS_RUN;
            end else if (step_evt) begin
              state    <= RS_STEP;
              step_ctr <= 8'(STEP_CYCLES - 1);
            end
          end
          RS_RUN: begin
            if (halt_req || !run_sync) state <= RS_HALT;
          end
          RS_STEP: begin
            if (halt_req) begin
              state <= RS_HALT;
            end else if (step_ctr == 8'd0) begin
              state     <= RS_HALT;
              step_done <= 1'b1;
            end else begin
              step_ctr <= step_ctr - 8'd1;
            end
          end
          default: state <= RS_HALT;
        endcase
      end
    end
  end

  assign stall_req = !((state == RS_RUN) || (state == RS_STEP));
  assign trapped   = (state == RS_TRAP);
  assign run_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_cnt <= '0;
    end else if (!stall_req && (adv_cnt != {CNT_W{1'b1}})) begin
      adv_cnt <= adv_cnt + 1'b1;
    end
  end

  logic unused_level;
  assign unused_level = step_level;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl with DB_CNT=4, STEP_CYCLES=3, CNT_W=4.
// Expected observations are queued by the driver and popped by the monitor.
module tb_pipe_run_ctrl;

  localparam int DB_CNT      = 4;
  localparam int DB_W        = 3;
  localparam int STEP_CYCLES = 3;
  localparam int CNT_W       = 4;
  localparam int W           = 3 + 1 + 1 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             run_sw;
  logic             step_btn;
  logic             halt_req;
  logic             trap;
  logic             stall_req;
  logic             step_done;
  logic             trapped;
  logic [2:0]       run_state;
  logic [CNT_W-1:0] adv_cnt;

  pipe_run_ctrl #(
    .DB_CNT     (DB_CNT),
    .DB_W       (DB_W),
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .trap     (trap),
    .stall_req(stall_req),
    .step_done(step_done),
    .trapped  (trapped),
    .run_state(run_state),
    .adv_cnt  (adv_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] done_q[$];
  logic [W-1:0]     exp_v;
  logic [W-1:0]     obs_v;
  logic             snap;
  int               total;
  int               bad;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_obs(input logic [2:0] st, input logic stall,
                            input logic trp, input logic [CNT_W-1:0] cnt);
    exp_q.push_back({st, stall, trp, cnt});
    snap = 1'b1;
    @(negedge clk);
    #1;
    snap = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  // Monitor: compares on each snapshot strobe and on every step_done pulse.
  always @(negedge clk) begin
    obs_v = {run_state, stall_req, trapped, adv_cnt};
    if (snap) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL snapshot: got %h, required an expectation in queue", obs_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs_v !== exp_v) begin
          bad++;
          $display("FAIL snapshot @%0t: got st=%0d stall=%b trap=%b cnt=%0d, required st=%0d stall=%b trap=%b cnt=%0d",
                   $time, obs_v[W-1 -: 3], obs_v[CNT_W+1], obs_v[CNT_W], obs_v[CNT_W-1:0],
                   exp_v[W-1 -: 3], exp_v[CNT_W+1], exp_v[CNT_W], exp_v[CNT_W-1:0]);
        end
      end
    end
    if (step_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL step_done: unexpected pulse @%0t, adv_cnt=%0d, required no pulse", $time, adv_cnt);
      end else if (adv_cnt !== done_q[0]) begin
        bad++;
        $display("FAIL step_done_cnt: got adv_cnt=%0d, required %0d", adv_cnt, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    snap     = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    trap     = 1'b0;
    rst_n    = 1'b0;
    #2;

    // Reset state, held and after a long idle
    expect_obs(3'd0, 1'b1, 1'b0, 4'd0);
    do_reset();
    ticks(50);
    expect_obs(3'd0, 1'b1, 1'b0, 4'd0);

    // Clean step press: STEP after 2+DB_CNT+1 edges, 3 advance cycles, then done
    do_reset();
    step_btn = 1'b1;
    ticks(7);
    expect_obs(3'd2, 1'b0, 1'b0, 4'd0);
    ticks(1);
    expect_obs(3'd2, 1'b0, 1'b0, 4'd1);
    done_q.push_back(4'd3);
    ticks(2);
    expect_obs(3'd0, 1'b1, 1'b0, 4'd3);
    ticks(10);
    step_btn = 1'b0;
    ticks(15);
    expect_obs(3'd0, 1'b1, 1'b0, 4'd3);

    // Bouncing button never holds long enough to register
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step_btn = ~step_btn;
      ticks(2);
    end
    step_btn = 1'b0;
    ticks(10);
    expect_obs(3'd0, 1'b1, 1'b0, 4'd0);

    // Run, one-cycle halt, resume, then switch off
    do_reset();
    run_sw = 1'b1;
    ticks(3);
    expect_obs(3'd1, 1'b0, 1'b0, 4'd0);
    ticks(10);
    halt_req = 1'b1;
    ticks(1);
    halt_req = 1'b0;
    expect_obs(3'd0, 1'b1, 1'b0, 4'd11);
    ticks(1);
    expect_obs(3'd1, 1'b0, 1'b0, 4'd11);
    run_sw = 1'b0;
    ticks(5);
    expect_obs(3'd0, 1'b1, 1'b0, 4'd14);

    // Trap wins over simultaneous halt and is absorbing until reset
    do_reset();
    run_sw = 1'b1;
    ticks(5);
    trap     = 1'b1;
    halt_req = 1'b1;
    ticks(1);
    trap     = 1'b0;
    halt_req = 1'b0;
    expect_obs(3'd3, 1'b1, 1'b1, 4'd3);
    step_btn = 1'b1;
    ticks(12);
    step_btn = 1'b0;
    run_sw   = 1'b0;
    ticks(4);
    run_sw = 1'b1;
    ticks(4);
    expect_obs(3'd3, 1'b1, 1'b1, 4'd3);
    run_sw = 1'b0;
    do_reset();
    expect_obs(3'd0, 1'b1, 1'b0, 4'd0);

    // Counter saturates at all-ones
    do_reset();
    run_sw = 1'b1;
    ticks(25);
    expect_obs(3'd1, 1'b0, 1'b0, 4'd15);
    ticks(5);
    expect_obs(3'd1, 1'b0, 1'b0, 4'd15);
    run_sw = 1'b0;

    // Reset during a step burst abandons it without step_done
    do_reset();
    step_btn = 1'b1;
    ticks(7);
    expect_obs(3'd2, 1'b0, 1'b0, 4'd0);
    ticks(1);
    expect_obs(3'd2, 1'b0, 1'b0, 4'd1);
    rst_n = 1'b0;
    expect_obs(3'd0, 1'b1, 1'b0, 4'd0);
    step_btn = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(10);
    expect_obs(3'd0, 1'b1, 1'b0, 4'd0);

    // Every queued expectation must have been consumed
    ticks(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_drain: got %0d left, required 0", exp_q.size());
    end
    total++;
    if (done_q.size() != 0) begin
      bad++;
      $display("FAIL done_q_drain: got %0d step_done pulses missing, required 0", done_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
